sram_frame_writer: RTL

- Write-side client for the single-port initialized frame SRAM used by the lab10 display path.
- Loads one rectangular frame (FRAME_W x FRAME_H words) into the SRAM starting at a runtime base address. Data comes either from a valid/ready pixel stream (e.g. UART loader) or from a constant fill value (clear/erase).
- Drives the SRAM en/we/addr/data_i pins; the display reader uses the SRAM only while this block is not busy.

---
 rtl/sram_frame_writer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/sram_frame_writer.sv
// sram_frame_writer: loads one FRAME_W x FRAME_H frame into the frame SRAM.
// The source is either a valid/ready stream or a constant fill value. The
// write address starts at a runtime base and wraps silently at the top of
// the address space.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   start, mode              begin a frame write (mode 0 = stream, 1 = fill); sampled in IDLE
//   base_addr, fill_val      first address and fill word, latched with start
//   abort                    ends an active operation; goes to DONE on the next edge
//   s_valid, s_data, s_ready stream input; s_ready is high exactly while in STREAM
//   sram_en/we/addr/data     registered SRAM write port
//   busy, done               busy in STREAM/FILL; done pulses for the single DONE cycle
//   words_written            words written by the last or current operation
module sram_frame_writer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned FRAME_W    = 64,
    parameter int unsigned FRAME_H    = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [DATA_WIDTH-1:0] fill_val,
    input  logic                  abort,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;
    localparam int unsigned FRAME_N = FRAME_W * FRAME_H;
    localparam logic [CNT_W-1:0] LAST_OFF = CNT_W'(FRAME_N - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FILL   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    // Offset of the next word; doubles as the words_written count.
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  s_ready_q, s_ready_d;
    logic                  sram_en_q, sram_en_d;
    logic                  sram_we_q, sram_we_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0] sram_data_q, sram_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_issue_c;

    // A write is issued on every stream handshake and on every FILL cycle.
    assign wr_issue_c = ((state_q == S_STREAM) && s_valid) || (state_q == S_FILL);

    // State register and datapath flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            s_ready_q   <= 1'b0;
            sram_en_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_addr_q <= '0;
            sram_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            s_ready_q   <= s_ready_d;
            sram_en_q   <= sram_en_d;
            sram_we_q   <= sram_we_d;
            sram_addr_q <= sram_addr_d;
            sram_data_q <= sram_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = mode ? S_FILL : S_STREAM;
                end
            end
            S_STREAM, S_FILL: begin
                if (abort || (wr_issue_c && (cnt_q == LAST_OFF))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath logic; status flags follow the next state so they
    // are registered in step with state_q.
    always_comb begin
        base_d      = base_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        sram_en_d   = 1'b0;
        sram_we_d   = 1'b0;
        sram_addr_d = sram_addr_q;
        sram_data_d = sram_data_q;

        if ((state_q == S_IDLE) && start) begin
            base_d = base_addr;
            fill_d = fill_val;
            cnt_d  = '0;
        end

        if (wr_issue_c) begin
            sram_en_d   = 1'b1;
            sram_we_d   = 1'b1;
            sram_addr_d = base_q + cnt_q[ADDR_WIDTH-1:0];
            sram_data_d = (state_q == S_STREAM) ? s_data : fill_q;
            cnt_d       = cnt_q + CNT_W'(1);
        end

        s_ready_d = (state_d == S_STREAM);
        busy_d    = (state_d == S_STREAM) || (state_d == S_FILL);
        done_d    = (state_d == S_DONE);
    end

    assign s_ready       = s_ready_q;
    assign sram_en       = sram_en_q;
    assign sram_we       = sram_we_q;
    assign sram_addr     = sram_addr_q;
    assign sram_data     = sram_data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign words_written = cnt_q;

endmodule
